// File: rtl/imem_boot_arbiter_pkg.sv
// Shared types and constants for the boot-time instruction-memory arbiter.
package imem_boot_arbiter_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 16384;
  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned LANE_W           = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2
  } boot_state_e;

  // Word-pointer width; a single-word image still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted loader bytes little-endian into a 32-bit word; cleared lanes
// stay zero, so a partial word is implicitly zero-padded when flushed.
module imem_byte_packer
  import imem_boot_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  input  logic              clear_i,
  output logic [LANE_W-1:0] byte_cnt_o,
  output logic              word_ready_c,
  output logic [31:0]       word_o
);

  logic [LANE_W-1:0] cnt_q;
  logic [LANE_W-1:0] cnt_d;
  logic [31:0]       shift_q;
  logic [31:0]       shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept_i) begin
      shift_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d                         = cnt_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_ready_c = accept_i && (cnt_q == LANE_W'(WORD_BYTES - 1));
  assign word_o       = shift_q;

endmodule

// File: rtl/imem_boot_arbiter.sv
// Shares the instruction SPRAM port between the byte-serial boot loader and
// CPU fetch. Optional macro IMEM_BOOT_CHECKSUM_EN adds the boot_csum output.
module imem_boot_arbiter
  import imem_boot_arbiter_pkg::*;
#(
  parameter int unsigned LOAD_WORDS   = 4096,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        ld_done,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        cpu_stall,
  output logic        boot_done,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [31:0] boot_csum
`endif
);

  localparam int unsigned      PTR_W    = ptr_width(LOAD_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LOAD_WORDS - 1);

  if (LOAD_WORDS < 1 || LOAD_WORDS > IMEM_DEPTH_WORDS) begin : g_bad_load_words
    $error("imem_boot_arbiter: LOAD_WORDS out of range");
  end
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("imem_boot_arbiter: RESET_VECTOR not word aligned");
  end

  boot_state_e       state_q;
  logic [PTR_W-1:0]  word_ptr_q;
  logic              done_q;
  logic              ld_ready_q;
  logic              wr_en_q;
  logic              cpu_stall_q;
  logic              boot_done_q;
  logic              fetch_valid_q;
  logic [31:0]       fetch_hold_q;

  logic              accept;
  logic              word_ready_c;
  logic [LANE_W-1:0] byte_cnt;
  logic [31:0]       packed_word;

  assign accept = ld_valid && ld_ready_q;

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (accept),
    .byte_i       (ld_byte),
    .clear_i      (state_q == ST_WRITE),
    .byte_cnt_o   (byte_cnt),
    .word_ready_c (word_ready_c),
    .word_o       (packed_word)
  );

  // Boot sequencing; ld_done with a partial or completing word is flushed
  // through one last WRITE before handing the port to fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      word_ptr_q    <= '0;
      done_q        <= 1'b0;
      ld_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      cpu_stall_q   <= 1'b1;
      boot_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_hold_q  <= '0;
    end else begin
      wr_en_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      if (fetch_valid_q) begin
        fetch_hold_q <= mem_data_out;
      end
      unique case (state_q)
        ST_LOAD: begin
          ld_ready_q <= 1'b1;
          if (word_ready_c) begin
            state_q    <= ST_WRITE;
            ld_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            done_q     <= ld_done;
          end else if (ld_done) begin
            ld_ready_q <= 1'b0;
            if (byte_cnt == '0 && !accept) begin
              state_q     <= ST_RUN;
              cpu_stall_q <= 1'b0;
              boot_done_q <= 1'b1;
            end else begin
              state_q <= ST_WRITE;
              wr_en_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (word_ptr_q == LAST_PTR || done_q) begin
            state_q     <= ST_RUN;
            cpu_stall_q <= 1'b0;
            boot_done_q <= 1'b1;
          end else begin
            state_q    <= ST_LOAD;
            word_ptr_q <= word_ptr_q + PTR_W'(1);
            ld_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          fetch_valid_q <= fetch_req;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // Address follows fetch combinationally once the CPU owns the memory.
  assign mem_addr    = (state_q == ST_RUN) ? fetch_addr
                                           : RESET_VECTOR + (32'(word_ptr_q) << 2);
  assign mem_wr_en   = wr_en_q;
  assign mem_data_in = packed_word;
  assign ld_ready    = ld_ready_q;
  assign cpu_stall   = cpu_stall_q;
  assign boot_done   = boot_done_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_valid_q ? mem_data_out : fetch_hold_q;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (wr_en_q) begin
      csum_q <= csum_q + mem_data_in;
    end
  end

  assign boot_csum = csum_q;
`endif

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a small SPRAM model (LOAD_WORDS=2).
module tb_imem_boot_arbiter;

  localparam int unsigned LW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_ready;
  logic        ld_done = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        cpu_stall;
  logic        boot_done;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'h0;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] boot_csum;
`endif

  always #5 clk = ~clk;

  imem_boot_arbiter #(.LOAD_WORDS(LW), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .ld_done      (ld_done),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .cpu_stall    (cpu_stall),
    .boot_done    (boot_done),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    .boot_csum    (boot_csum)
`endif
  );

  // Synchronous SPRAM model, read data one cycle after the address.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[5:2]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[5:2]];
  end

  int          wr_cnt = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          bad_ready_tot = 0;
  int          overlap_tot = 0;
  int          fv_load_tot = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt = 0;
    end else if (mem_wr_en) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_data_in;
      end
      wr_cnt++;
      if (ld_ready) bad_ready_tot++;
      if (fetch_valid) overlap_tot++;
    end
    if (rst_n && fetch_valid && !boot_done) fv_load_tot++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_done   = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit took = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    for (int i = 0; i < 20 && !took; i++) begin
      if (ld_ready) took = 1'b1;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check_eq("byte_handshake", 32'(took), 32'd1);
  endtask

  logic [31:0] b2b_exp [3];
  int          seen;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    check_eq("rst_boot_done", 32'(boot_done), 32'd0);
    check_eq("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_fetch_data", fetch_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ld_ready", 32'(ld_ready), 32'd1);

    // First word: 78 56 34 12.
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check_eq("w0_wr_en", 32'(mem_wr_en), 32'd1);
    check_eq("w0_addr", mem_addr, 32'h0);
    check_eq("w0_data", mem_data_in, 32'h1234_5678);
    check_eq("w0_ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    check_eq("w0_wr_en_drop", 32'(mem_wr_en), 32'd0);
    check_eq("w0_ready_back", 32'(ld_ready), 32'd1);
    check_eq("w0_count", 32'(wr_cnt), 32'd1);

    // Full image of two words, then an unacknowledged ninth byte.
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check_eq("w1_addr", mem_addr, 32'h4);
    check_eq("w1_data", mem_data_in, 32'h0807_0605);
    @(negedge clk);
    check_eq("full_boot_done", 32'(boot_done), 32'd1);
    check_eq("full_cpu_stall", 32'(cpu_stall), 32'd0);
    check_eq("full_wr_count", 32'(wr_cnt), 32'd2);
    check_eq("full_wr0_addr", wr_addr[0], 32'h0);
    check_eq("full_wr0_data", wr_data[0], 32'h0403_0201);
    check_eq("full_wr1_addr", wr_addr[1], 32'h4);
    ld_valid = 1'b1;
    ld_byte  = 8'h09;
    seen     = 0;
    repeat (5) begin
      if (ld_ready) seen++;
      @(negedge clk);
    end
    check_eq("ninth_byte_ready", 32'(seen), 32'd0);

    // Fetch in RUN with the loader still pushing.
    fetch_addr = 32'h4;
    fetch_req  = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    check_eq("fetch4_valid", 32'(fetch_valid), 32'd1);
    check_eq("fetch4_data", fetch_data, 32'h0807_0605);
    @(negedge clk);
    check_eq("fetch_idle_valid", 32'(fetch_valid), 32'd0);
    check_eq("fetch_hold_data", fetch_data, 32'h0807_0605);
    b2b_exp[0] = 32'h0403_0201;
    b2b_exp[1] = 32'h0807_0605;
    b2b_exp[2] = 32'hA000_0002;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(4 * i);
      @(negedge clk);
      check_eq($sformatf("b2b_valid_%0d", i), 32'(fetch_valid), 32'd1);
      check_eq($sformatf("b2b_data_%0d", i), fetch_data, b2b_exp[i]);
    end
    fetch_req = 1'b0;
    ld_valid  = 1'b0;
    check_eq("run_no_writes", 32'(wr_cnt), 32'd2);

    // Partial word flushed by ld_done.
    do_reset();
    send_byte(8'hAA); send_byte(8'hBB);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    check_eq("pad_wr_en", 32'(mem_wr_en), 32'd1);
    check_eq("pad_addr", mem_addr, 32'h0);
    check_eq("pad_data", mem_data_in, 32'h0000_BBAA);
    @(negedge clk);
    check_eq("pad_boot_done", 32'(boot_done), 32'd1);
    check_eq("pad_wr_count", 32'(wr_cnt), 32'd1);

    // ld_done on an empty word goes straight to RUN; first RUN cycle has no response.
    do_reset();
    fetch_addr = 32'h0;
    fetch_req  = 1'b1;
    ld_done    = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    check_eq("empty_boot_done", 32'(boot_done), 32'd1);
    check_eq("empty_first_run_valid", 32'(fetch_valid), 32'd0);
    check_eq("empty_wr_count", 32'(wr_cnt), 32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    check_eq("empty_fetch_valid", 32'(fetch_valid), 32'd1);
    check_eq("empty_fetch_data", fetch_data, 32'h0000_BBAA);

    // Reset after five bytes restarts at word 0.
    do_reset();
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
    do_reset();
    fetch_req = 1'b1;
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    check_eq("rr_addr", mem_addr, 32'h0);
    check_eq("rr_data", mem_data_in, 32'h2423_2221);
    check_eq("rr_wr_en", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    check_eq("rr_wr_count", 32'(wr_cnt), 32'd1);
    check_eq("rr_stall", 32'(cpu_stall), 32'd1);
    fetch_req = 1'b0;

`ifdef IMEM_BOOT_CHECKSUM_EN
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check_eq("csum_after_w0", boot_csum, 32'h1);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    check_eq("csum_boot_done", 32'(boot_done), 32'd1);
    check_eq("csum_final", boot_csum, 32'h0);
`endif

    check_eq("wr_with_ld_ready", 32'(bad_ready_tot), 32'd0);
    check_eq("wr_with_fetch_valid", 32'(overlap_tot), 32'd0);
    check_eq("fetch_valid_in_load", 32'(fv_load_tot), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
